// File: rtl/uart_transmitter.sv
// UART transmitter: 11-bit frames (start, 8 data LSB-first, odd parity, stop), valid/ready input.
// Define UART_TX_FIFO_EN to place a FIFO_DEPTH-entry FIFO between the handshake and the FSM.
module uart_transmitter #(
    parameter int CLKS_PER_BIT = 4,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       busy
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t        state, state_next;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift_reg;
    logic          parity_bit;
    logic          tx_next;
    logic          bit_done;
    logic          start_frame;
    logic [7:0]    load_byte;

    if (CLKS_PER_BIT < 2 || FIFO_DEPTH < 1) begin : g_param_check
        $error("uart_transmitter: CLKS_PER_BIT must be >= 2 and FIFO_DEPTH >= 1");
    end

    assign bit_done = (baud_cnt == CW'(CLKS_PER_BIT - 1));
    assign busy     = (state != IDLE);

`ifdef UART_TX_FIFO_EN
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          push, pop, full, empty;

    assign full        = (count == (AW+1)'(FIFO_DEPTH));
    assign empty       = (count == '0);
    assign tx_ready    = !full;
    assign push        = data_valid && !full;
    assign pop         = (state == IDLE) && !empty;
    assign start_frame = pop;
    assign load_byte   = fifo_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == AW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == AW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
`else
    assign tx_ready    = (state == IDLE);
    assign start_frame = data_valid && (state == IDLE);
    assign load_byte   = data_in;
`endif

    // tx is registered from the current state, so the line trails the FSM by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
            tx         <= 1'b1;
        end else begin
            state <= state_next;
            tx    <= tx_next;
            if (state == IDLE) begin
                baud_cnt <= '0;
                bit_idx  <= '0;
                if (start_frame) begin
                    shift_reg  <= load_byte;
                    parity_bit <= ~^load_byte;
                end
            end else begin
                baud_cnt <= bit_done ? '0 : baud_cnt + 1'b1;
                if (state == DATA && bit_done) begin
                    shift_reg <= shift_reg >> 1;
                    bit_idx   <= bit_idx + 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_next = state;
        tx_next    = 1'b1;
        case (state)
            IDLE: begin
                if (start_frame) state_next = START;
            end
            START: begin
                tx_next = 1'b0;
                if (bit_done) state_next = DATA;
            end
            DATA: begin
                tx_next = shift_reg[0];
                if (bit_done && bit_idx == 3'd7) state_next = PARITY;
            end
            PARITY: begin
                tx_next = parity_bit;
                if (bit_done) state_next = STOP;
            end
            STOP: begin
                if (bit_done) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed self-checking bench for uart_transmitter (CLKS_PER_BIT=4).
// Outputs are sampled on the falling edge; inputs also change there.
module tb_uart_transmitter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       data_valid = 1'b0;
    logic       tx_ready, tx, busy;

    int vectors = 0;
    int miscompares = 0;

`ifdef UART_TX_FIFO_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    always #5 clk = ~clk;

    uart_transmitter #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .data_valid (data_valid),
        .tx_ready   (tx_ready),
        .tx         (tx),
        .busy       (busy)
    );

    // rel counts cycles after the START state was entered; rel 0 still shows idle.
    function automatic logic expected_tx(input logic [7:0] d, input int rel);
        logic [10:0] frame;
        frame = {1'b1, ~^d, d, 1'b0};
        if (rel < 1 || rel > 44) return 1'b1;
        return frame[(rel - 1) / 4];
    endfunction

    task automatic wait_ready(input string name);
        int w;
        w = 0;
        while (tx_ready !== 1'b1 && w < 200) begin
            @(negedge clk);
            w++;
        end
        vectors++;
        if (tx_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL %s ready timeout: tx_ready got %b want 1", name, tx_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({tx, tx_ready, busy} !== 3'b110) begin
            miscompares++;
            $display("[TB] FAIL reset_held {tx,ready,busy} got %b want 110", {tx, tx_ready, busy});
        end
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            vectors++;
            if ({tx, tx_ready, busy} !== 3'b110) begin
                miscompares++;
                $display("[TB] FAIL reset_idle c=%0d {tx,ready,busy} got %b want 110", c, {tx, tx_ready, busy});
            end
        end
    endtask

    task automatic test_frame(input logic [7:0] d, input string name);
        int  busy_cnt;
        logic exp_tx, exp_busy;
        wait_ready(name);
        data_in    = d;
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        data_in    = 8'hC3;
        busy_cnt   = 0;
        for (int c = 0; c <= 46 + LAT; c++) begin
            if (c > 0) @(negedge clk);
            exp_tx   = expected_tx(d, c - LAT);
            exp_busy = (c - LAT >= 0) && (c - LAT < 44);
            if (busy === 1'b1) busy_cnt++;
            vectors++;
            if (tx !== exp_tx || busy !== exp_busy) begin
                miscompares++;
                $display("[TB] FAIL %s c=%0d tx/busy got %b%b want %b%b", name, c, tx, busy, exp_tx, exp_busy);
            end
        end
        vectors++;
        if (busy_cnt != 44) begin
            miscompares++;
            $display("[TB] FAIL %s busy_len got %0d want 44", name, busy_cnt);
        end
    endtask

`ifndef UART_TX_FIFO_EN
    task automatic test_ignore();
        logic exp_tx, exp_busy;
        wait_ready("ignore");
        data_in    = 8'h5A;
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        for (int c = 0; c < 70; c++) begin
            if (c > 0) @(negedge clk);
            exp_tx   = expected_tx(8'h5A, c);
            exp_busy = (c < 44);
            vectors++;
            if (tx !== exp_tx || busy !== exp_busy) begin
                miscompares++;
                $display("[TB] FAIL ignore c=%0d tx/busy got %b%b want %b%b", c, tx, busy, exp_tx, exp_busy);
            end
            if (c == 10) begin
                vectors++;
                if (tx_ready !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL ignore_ready got %b want 0", tx_ready);
                end
                data_in    = 8'h3C;
                data_valid = 1'b1;
            end
            if (c == 11) data_valid = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d;
        int   rel;
        logic exp_tx, exp_busy;
        wait_ready("b2b");
        data_in    = 8'h81;
        data_valid = 1'b1;
        @(negedge clk);
        data_in = 8'h7E;
        for (int c = 0; c < 94; c++) begin
            if (c > 0) @(negedge clk);
            d        = (c < 45) ? 8'h81 : 8'h7E;
            rel      = (c < 45) ? c : c - 45;
            exp_tx   = expected_tx(d, rel);
            exp_busy = (rel < 44);
            vectors++;
            if (tx !== exp_tx || busy !== exp_busy) begin
                miscompares++;
                $display("[TB] FAIL b2b c=%0d tx/busy got %b%b want %b%b", c, tx, busy, exp_tx, exp_busy);
            end
            if (c == 44) begin
                vectors++;
                if (tx_ready !== 1'b1) begin
                    miscompares++;
                    $display("[TB] FAIL b2b_gap_ready got %b want 1", tx_ready);
                end
            end
            if (c == 46) data_valid = 1'b0;
        end
    endtask
`else
    task automatic test_fifo();
        logic [7:0] bytes [6];
        logic exp_tx, exp_busy, exp_ready;
        bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        wait_ready("fifo");
        for (int c = -2; c <= 275; c++) begin
            if (c > -2) @(negedge clk);
            if (c < 0 || c / 45 > 5) exp_tx = 1'b1;
            else                     exp_tx = expected_tx(bytes[c / 45], c % 45);
            exp_busy  = (c >= 0) && (c < 269) && ((c % 45) != 44);
            exp_ready = (c <= 2) || (c == 45) || (c >= 90);
            vectors++;
            if (tx !== exp_tx || busy !== exp_busy || tx_ready !== exp_ready) begin
                miscompares++;
                $display("[TB] FAIL fifo c=%0d tx/busy/ready got %b%b%b want %b%b%b",
                         c, tx, busy, tx_ready, exp_tx, exp_busy, exp_ready);
            end
            if (c <= 3) begin
                data_in    = bytes[c + 2];
                data_valid = 1'b1;
            end
            if (c == 46) data_valid = 1'b0;
        end
    endtask
`endif

    task automatic test_reset_mid_frame(input logic [7:0] d, input int at, input string name);
        logic exp_tx;
        wait_ready(name);
        data_in    = d;
        data_valid = 1'b1;
        @(negedge clk);
        data_in = 8'h12;
        @(negedge clk);
        data_valid = 1'b0;
        for (int c = 1; c < at + LAT; c++) @(negedge clk);
        exp_tx = expected_tx(d, at);
        vectors++;
        if (tx !== exp_tx || busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL %s pre_reset tx/busy got %b%b want %b1", name, tx, busy, exp_tx);
        end
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if ({tx, tx_ready, busy} !== 3'b110) begin
            miscompares++;
            $display("[TB] FAIL %s after_reset {tx,ready,busy} got %b want 110", name, {tx, tx_ready, busy});
        end
        rst = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            vectors++;
            if (tx !== 1'b1 || busy !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL %s no_resume c=%0d tx/busy got %b%b want 10", name, c, tx, busy);
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_frame(8'hA5, "frame_a5");
        test_frame(8'h01, "frame_01");
        test_frame(8'h00, "frame_00");
`ifndef UART_TX_FIFO_EN
        test_ignore();
        test_back_to_back();
`else
        test_fifo();
`endif
        test_reset_mid_frame(8'hFF, 17, "rst_data3");
        test_reset_mid_frame(8'h00, 2, "rst_start");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
